// File: rtl/simple_pkg.sv
// Shared types and default widths for the SIMPLE pipeline memory-port logic.
package simple_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-access and RAM-port signals around the memory arbiter.
interface mem_port_arbiter_if
  import simple_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;

  logic          dm_re;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;
  logic          stall;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  // Pipeline and RAM side
  modport master (
    output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_q,
    input  if_ready, if_rdata, dm_ready, dm_rdata, stall,
           mem_addr, mem_wdata, mem_wren
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_q,
    output if_ready, if_rdata, dm_ready, dm_rdata, stall,
           mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and data access; data has priority,
// a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
  import simple_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned  CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wren_q,  wren_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic dm_req;
  logic dm_done;
  logic if_done;

  assign dm_req = bus.dm_re | bus.dm_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration in IDLE; RAM port latched on the grant edge, write strobe lasts one ACC cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req && (!dm_req || (cnt_q == LIMIT))) begin
          state_d = ACC;
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          cnt_d   = '0;
        end else if (dm_req) begin
          state_d = ACC;
          owner_d = OWN_DM;
          addr_d  = bus.dm_addr;
          if (bus.dm_we) begin
            wdata_d = bus.dm_wdata;
            wren_d  = 1'b1;
          end
          if (!bus.if_req) begin
            cnt_d = '0;
          end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ACC: begin
        state_d = wren_q ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write completes in ACC, reads complete in RESP when RAM data is valid
  assign dm_done = (owner_q == OWN_DM) &&
                   (((state_q == ACC) && wren_q) || (state_q == RESP));
  assign if_done = (owner_q == OWN_IF) && (state_q == RESP);

  assign bus.dm_ready  = dm_done;
  assign bus.dm_rdata  = (dm_done && (state_q == RESP)) ? bus.mem_q : '0;
  assign bus.if_ready  = if_done;
  assign bus.if_rdata  = if_done ? bus.mem_q : '0;
  assign bus.stall     = dm_req & ~dm_done;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wren  = wren_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected ready pulses, a monitor checks them.
module tb_mem_port_arbiter;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t if_q[$];
  exp_t dm_q[$];
  exp_t e;

  logic [15:0] ram [0:4095];

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with registered read data
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr[11:0]] <= bus.mem_wdata;
    bus.mem_q <= ram[bus.mem_addr[11:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [15:0] d, input int c);
    if_q.push_back('{data: d, cyc: c});
  endtask

  task automatic push_dm(input logic [15:0] d, input int c);
    dm_q.push_back('{data: d, cyc: c});
  endtask

  // Monitor: every ready pulse must match the oldest expectation for that port
  always @(negedge clk) begin
    if (bus.if_ready) begin
      if (if_q.size() == 0) begin
        check("if_unexpected_ready", 32'(bus.if_ready), 32'd0);
      end else begin
        e = if_q.pop_front();
        check("if_rdata", 32'(bus.if_rdata), 32'(e.data));
        check("if_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("if_rdata_zero", 32'(bus.if_rdata), 32'd0);
    end
    if (bus.dm_ready) begin
      if (dm_q.size() == 0) begin
        check("dm_unexpected_ready", 32'(bus.dm_ready), 32'd0);
      end else begin
        e = dm_q.pop_front();
        check("dm_rdata", 32'(bus.dm_rdata), 32'(e.data));
        check("dm_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("dm_rdata_zero", 32'(bus.dm_rdata), 32'd0);
    end
  end

  initial begin
    int n;
    int s;
    reset        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_re    = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    ram[12'h010] = 16'hBEEF;
    ram[12'h020] = 16'hAAAA;
    ram[12'h300] = 16'h5555;
    ram[12'h040] = 16'h4040;
    ram[12'h050] = 16'h5050;

    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_mem_wren",  32'(bus.mem_wren),  32'd0);
    check("rst_stall",     32'(bus.stall),     32'd0);

    // Fetch alone
    tick();
    n = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    push_if(16'hBEEF, n + 2);
    @(negedge clk);
    check("fetch_stall_0", 32'(bus.stall), 32'd0);
    tick();
    @(negedge clk);
    check("fetch_mem_addr", 32'(bus.mem_addr), 32'h0010);
    check("fetch_stall_1", 32'(bus.stall), 32'd0);
    check("fetch_no_wren", 32'(bus.mem_wren), 32'd0);
    tick();
    @(negedge clk);
    check("fetch_stall_2", 32'(bus.stall), 32'd0);
    tick();
    bus.if_req = 1'b0;

    // Store then load
    n = cyc;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0200;
    bus.dm_wdata = 16'h1234;
    push_dm(16'h0000, n + 1);
    @(negedge clk);
    check("store_stall", 32'(bus.stall), 32'd1);
    check("store_wren_idle", 32'(bus.mem_wren), 32'd0);
    tick();
    @(negedge clk);
    check("store_wren", 32'(bus.mem_wren), 32'd1);
    check("store_addr", 32'(bus.mem_addr), 32'h0200);
    check("store_wdata", 32'(bus.mem_wdata), 32'h1234);
    check("store_stall_fall", 32'(bus.stall), 32'd0);
    tick();
    bus.dm_we = 1'b0;
    bus.dm_re = 1'b1;
    n = cyc;
    push_dm(16'h1234, n + 2);
    @(negedge clk);
    check("wren_one_cycle", 32'(bus.mem_wren), 32'd0);
    check("load_stall_0", 32'(bus.stall), 32'd1);
    tick();
    @(negedge clk);
    check("load_stall_1", 32'(bus.stall), 32'd1);
    tick();
    @(negedge clk);
    check("load_stall_fall", 32'(bus.stall), 32'd0);
    tick();
    bus.dm_re = 1'b0;

    // Simultaneous requests: data first, fetch in the following IDLE
    n = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0020;
    bus.dm_re   = 1'b1;
    bus.dm_addr = 16'h0300;
    push_dm(16'h5555, n + 2);
    push_if(16'hAAAA, n + 5);
    tick();
    @(negedge clk);
    check("simul_dm_first", 32'(bus.mem_addr), 32'h0300);
    tick();
    tick();
    bus.dm_re = 1'b0;
    tick();
    @(negedge clk);
    check("simul_if_second", 32'(bus.mem_addr), 32'h0020);
    tick();
    tick();
    bus.if_req = 1'b0;

    // Starvation: four data grants, then fetch, then data again after counter clears
    s = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0040;
    bus.dm_re   = 1'b1;
    bus.dm_addr = 16'h0050;
    push_dm(16'h5050, s + 2);
    push_dm(16'h5050, s + 5);
    push_dm(16'h5050, s + 8);
    push_dm(16'h5050, s + 11);
    push_if(16'h4040, s + 14);
    push_dm(16'h5050, s + 17);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 13) begin
        @(negedge clk);
        check("starve_fetch_grant", 32'(bus.mem_addr), 32'h0040);
      end
      if (k == 16) begin
        @(negedge clk);
        check("starve_cleared", 32'(bus.mem_addr), 32'h0050);
      end
    end
    bus.if_req = 1'b0;

    // Data read dropped during ACC still completes; no further access
    n = cyc;
    bus.dm_addr = 16'h0200;
    push_dm(16'h1234, n + 2);
    tick();
    bus.dm_re = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("drop_no_new_addr", 32'(bus.mem_addr), 32'h0200);
    check("drop_no_wren", 32'(bus.mem_wren), 32'd0);
    check("drop_stall", 32'(bus.stall), 32'd0);

    // Reset during ACC of a write
    tick();
    n = cyc;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0600;
    bus.dm_wdata = 16'hDEAD;
    push_dm(16'h0000, n + 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rstw_acc_wren", 32'(bus.mem_wren), 32'd1);
    tick();
    bus.dm_we = 1'b0;
    @(negedge clk);
    check("rstw_wren", 32'(bus.mem_wren), 32'd0);
    check("rstw_addr", 32'(bus.mem_addr), 32'd0);
    check("rstw_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rstw_dm_ready", 32'(bus.dm_ready), 32'd0);
    check("rstw_stall", 32'(bus.stall), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstw_after_wren", 32'(bus.mem_wren), 32'd0);

    // Reset during an in-flight read drops it
    tick();
    bus.dm_re   = 1'b1;
    bus.dm_addr = 16'h0050;
    tick();
    reset = 1'b1;
    tick();
    bus.dm_re = 1'b0;
    @(negedge clk);
    check("rstr_addr", 32'(bus.mem_addr), 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();

    check("if_queue_empty", 32'(if_q.size()), 32'd0);
    check("dm_queue_empty", 32'(dm_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 16-bit main memory of the SIMPLE pipeline between instruction fetch (p1) and the data-access path (p3 `readEnable`/`writeEnable`/`Address`/`storeData`). Sequences each access through a 3-state FSM, returns read data with a one-cycle ready pulse, and raises `stall` to freeze the pipeline while a data access is outstanding. Data has priority; a starvation counter guarantees fetch progress.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `STARVE_LIMIT`, 4, consecutive data grants allowed while fetch waits (≥1)

- `clk` in 1: single clock, all state on posedge
- `reset` in 1: synchronous, active-high
- `if_req` in 1: fetch read request, level, held until `if_ready`
- `if_addr` in AW: fetch address
- `if_ready` out 1: one-cycle pulse, `if_rdata` valid
- `if_rdata` out DW: fetch data, 0 when `if_ready`=0
- `dm_re` in 1: data read request, level
- `dm_we` in 1: data write request, level
- `dm_addr` in AW: data address
- `dm_wdata` in DW: store data
- `dm_ready` out 1: one-cycle pulse, read data valid / write committed
- `dm_rdata` out DW: load data, 0 when `dm_ready`=0
- `stall` out 1: pipeline freeze
- `mem_addr` out AW, `mem_wdata` out DW, `mem_wren` out 1: registered RAM port
- `mem_q` in DW: RAM read data, valid the cycle after RAM samples `mem_addr`

## Operation
- States: IDLE, ACC, RESP; `owner` register (IF/DM) records granted requester.
- IDLE arbitration: data request = `dm_re|dm_we`. Fetch wins iff `if_req` && (no data request || `starve_cnt`==STARVE_LIMIT); else data wins if requested; else stay IDLE.
- On grant edge: latch `mem_addr` (and `mem_wdata`, `mem_wren`=1 for write) from winner; state→ACC.
- ACC, read: RAM samples address; next state RESP. ACC, write: `mem_wren`=1 this cycle only, `dm_ready`=1 (combinational), next state IDLE.
- RESP: owner's `*_ready`=1, `*_rdata`=`mem_q`; next state IDLE.
- `dm_re`&`dm_we` together: treated as write.
- `starve_cnt`: +1 (saturating at STARVE_LIMIT) on each data grant while `if_req`=1; cleared on fetch grant or in IDLE with `if_req`=0.
- `stall` = (`dm_re|dm_we`) & ~`dm_ready`, combinational.
- Requester drops request mid-access: access completes, ready pulse still issued, requester ignores it.
- Request still held in IDLE after its ready pulse is a new access.

## Timing
- Reset values: state IDLE, owner IF, `mem_addr`/`mem_wdata` 0, `mem_wren` 0, `starve_cnt` 0; ready outputs 0, rdata outputs 0.
- Reset mid-operation: at that edge `mem_wren` forced 0, in-flight read dropped, no ready pulse afterward.
- Read: request first seen in IDLE cycle n → ready in cycle n+2; 3 cycles per read (IDLE, ACC, RESP).
- Write: request in cycle n → `mem_wren`=1 and `dm_ready`=1 in cycle n+1; 2 cycles per write.
- `mem_wren` never high outside ACC; no back-to-back accesses without an IDLE cycle.
- `stall` falls in the same cycle `dm_ready` rises.

## Structure
- Shared package `simple_pkg`: state enum (IDLE/ACC/RESP), owner enum (IF/DM), default AW/DW constants.
- Single module; starvation counter and FSM inline, no sub-module.

## Test plan
- Fetch alone: `if_req`=1, `if_addr`=0x0010, RAM[0x0010]=0xBEEF → `if_ready` pulse cycle n+2, `if_rdata`=0xBEEF, `stall`=0 throughout.
- Store then load: `dm_we`, addr 0x0200, data 0x1234 → `mem_wren`=1 one cycle, `dm_ready` at n+1; then `dm_re` 0x0200 → `dm_rdata`=0x1234 at n+2, `stall` high until each ready.
- Simultaneous `if_req` and `dm_re` in IDLE, `starve_cnt`=0 → data granted first, fetch granted in next IDLE, `starve_cnt` 1 then 0.
- Continuous data requests with `if_req` held, STARVE_LIMIT=4 → four data grants, fifth grant to fetch, counter clears.
- `reset` asserted during ACC of a write → `mem_wren`=0 next cycle, state IDLE, no `dm_ready`, all outputs at reset values.
- `dm_re` dropped during ACC → `dm_ready` still pulses in RESP, next IDLE issues no access.
